// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI receiver: default sizes, FSM state
// encodings (one-hot) and the bit-counter width helper.
package dac_spi_pkg;

    localparam int DATA_WIDTH_DEF  = 24;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [1:0] ST_IDLE  = 2'b01;
    localparam logic [1:0] ST_SHIFT = 2'b10;

    // Counter must reach DATA_WIDTH+1 so over-long frames stay detectable.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/dac_spi_in_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchroniser followed by one edge-detect flop.
// Ports: i_Clock/i_Reset, i_Async (raw input), o_Level (aligned level),
//        o_Rise / o_Fall (registered one-cycle edge pulses aligned with o_Level).
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_Async,
    output logic o_Level,
    output logic o_Rise,
    output logic o_Fall
);

    logic [SYNC_STAGES-1:0] r_Sync;
    logic                   r_Prev;
    logic                   r_Rise;
    logic                   r_Fall;
    logic                   w_Sync;

    assign w_Sync = r_Sync[SYNC_STAGES-1];

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Sync <= {SYNC_STAGES{RESET_VAL}};
            r_Prev <= RESET_VAL;
            r_Rise <= 1'b0;
            r_Fall <= 1'b0;
        end else begin
            r_Sync <= {r_Sync[SYNC_STAGES-2:0], i_Async};
            r_Prev <= w_Sync;
            // Pulses are registered alongside r_Prev so level and edge line up.
            r_Rise <= w_Sync & ~r_Prev;
            r_Fall <= ~w_Sync & r_Prev;
        end
    end

    assign o_Level = r_Prev;
    assign o_Rise  = r_Rise;
    assign o_Fall  = r_Fall;

endmodule

// File: rtl/dac_spi_in.sv
// dac_spi_in: oversampling SPI slave receiver (CS low, SCK idle high, MSB first).
// Ports: i_Clock, i_Reset (async high), i_SPI_CS/Clock/Data (async SPI inputs),
//        o_Data (last good word), o_Valid / o_Frame_Error (1-cycle pulses), o_Busy.
module dac_spi_in
    import dac_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SPI_CS,
    input  logic                  i_SPI_Clock,
    input  logic                  i_SPI_Data,
    output logic [DATA_WIDTH-1:0] o_Data,
    output logic                  o_Valid,
    output logic                  o_Frame_Error,
    output logic                  o_Busy
);

    localparam int            CW     = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] C_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] C_SAT  = CW'(DATA_WIDTH + 1);

    logic                  w_Cs_Level;
    logic                  w_Cs_Rise;
    logic                  w_Cs_Fall;
    logic                  w_Sck_Level;
    logic                  w_Sck_Rise;
    logic                  w_Sck_Fall;
    logic                  w_Data;
    logic                  w_unused_ok;
    logic [CW-1:0]         w_Count_Next;
    logic [DATA_WIDTH-1:0] w_Shift_Next;

    logic [SYNC_STAGES:0]  r_Data_Sync;
    logic [SYNC_STAGES:0]  r_Settle;
    logic                  r_Armed;
    logic [1:0]            r_State;
    logic [CW-1:0]         r_Count;
    logic [DATA_WIDTH-1:0] r_Shift;
    logic [DATA_WIDTH-1:0] r_Data;
    logic                  r_Valid;
    logic                  r_Frame_Error;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_SPI_CS),
        .o_Level (w_Cs_Level),
        .o_Rise  (w_Cs_Rise),
        .o_Fall  (w_Cs_Fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Async (i_SPI_Clock),
        .o_Level (w_Sck_Level),
        .o_Rise  (w_Sck_Rise),
        .o_Fall  (w_Sck_Fall)
    );

    assign w_unused_ok = w_Sck_Level ^ w_Sck_Fall;

    // Extra stage keeps data at the same depth as the registered SCK edge.
    assign w_Data = r_Data_Sync[SYNC_STAGES];

    assign w_Count_Next = !w_Sck_Rise    ? r_Count :
                          (r_Count == C_SAT) ? r_Count : r_Count + 1'b1;
    assign w_Shift_Next = w_Sck_Rise ? {r_Shift[DATA_WIDTH-2:0], w_Data} : r_Shift;

    // Synchronisers reset to idle-high; until a genuine CS-high has been seen
    // after reset, a CS fall is a reset artefact (or a frame already under way).
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_Data_Sync <= '0;
            r_Settle    <= '0;
            r_Armed     <= 1'b0;
        end else begin
            r_Data_Sync <= {r_Data_Sync[SYNC_STAGES-1:0], i_SPI_Data};
            r_Settle    <= {r_Settle[SYNC_STAGES-1:0], 1'b1};
            r_Armed     <= r_Armed | (r_Settle[SYNC_STAGES] & w_Cs_Level);
        end
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            r_State       <= ST_IDLE;
            r_Count       <= '0;
            r_Shift       <= '0;
            r_Data        <= '0;
            r_Valid       <= 1'b0;
            r_Frame_Error <= 1'b0;
        end else begin
            r_Valid       <= 1'b0;
            r_Frame_Error <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (w_Cs_Fall && r_Armed) begin
                        r_State <= ST_SHIFT;
                        r_Count <= '0;
                        r_Shift <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_Shift <= w_Shift_Next;
                    r_Count <= w_Count_Next;
                    // A coincident SCK bit is already folded into *_Next.
                    if (w_Cs_Rise) begin
                        r_State <= ST_IDLE;
                        if (w_Count_Next == C_FULL) begin
                            r_Data  <= w_Shift_Next;
                            r_Valid <= 1'b1;
                        end else begin
                            r_Frame_Error <= 1'b1;
                        end
                    end
                end
                default: r_State <= ST_IDLE;
            endcase
        end
    end

    assign o_Data        = r_Data;
    assign o_Valid       = r_Valid;
    assign o_Frame_Error = r_Frame_Error;
    assign o_Busy        = (r_State == ST_SHIFT);

endmodule
